// File: rtl/relu_maxpool_13_2.sv
`default_nettype none
// =============================================================================
// Module : relu_maxpool_13_2
// Brief  : Optional ReLU, then non-overlapping max-pool (window/stride W)
//          over N-element vectors on a valid/ready stream.
// Rev    : 1.0 - initial release
// =============================================================================
module relu_maxpool_13_2 #(
  parameter int T    = 16,
  parameter int N    = 13,
  parameter int W    = 2,
  parameter bit RELU = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [T-1:0] x_data,
  input  logic         x_valid,
  output logic         x_ready,
  output logic [T-1:0] y_data,
  output logic         y_valid,
  input  logic         y_ready
);

  localparam int c_K  = N / W;
  localparam int c_NP = c_K * W;
  localparam int c_IW = $clog2(N + 1);
  localparam int c_PW = (W > 1) ? $clog2(W) : 1;

  logic [c_IW-1:0]     r_idx;
  logic [c_PW-1:0]     r_pos;
  logic signed [T-1:0] r_acc;
  logic signed [T-1:0] r_y_data;
  logic                r_y_valid;

  logic                w_accept;
  logic                w_in_pool;
  logic                w_last_pos;
  logic                w_last_idx;
  logic                w_load;
  logic signed [T-1:0] w_act;
  logic signed [T-1:0] w_max;
  logic signed [T-1:0] w_result;

  assign x_ready    = ~r_y_valid | y_ready;
  assign w_accept   = x_valid & x_ready;
  assign w_act      = (RELU && x_data[T-1]) ? '0 : $signed(x_data);
  assign w_max      = (w_act > r_acc) ? w_act : r_acc;
  assign w_result   = (W == 1) ? w_act : w_max;
  assign w_in_pool  = (r_idx < c_IW'(c_NP));
  assign w_last_pos = (r_pos == c_PW'(W - 1));
  assign w_last_idx = (r_idx == c_IW'(N - 1));
  assign w_load     = w_accept & w_in_pool & w_last_pos;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_idx     <= '0;
      r_pos     <= '0;
      r_acc     <= '0;
      r_y_data  <= '0;
      r_y_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        // Window position restarts with every vector so a trailing partial
        // window never leaks into the next vector's first window.
        if (w_last_idx) begin
          r_idx <= '0;
          r_pos <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
          r_pos <= w_last_pos ? '0 : r_pos + 1'b1;
        end
        if (w_in_pool && !w_last_pos) begin
          r_acc <= (r_pos == '0) ? w_act : w_max;
        end
      end
      if (w_load) begin
        r_y_data  <= w_result;
        r_y_valid <= 1'b1;
      end else if (y_ready) begin
        r_y_valid <= 1'b0;
      end
    end
  end

  assign y_data  = r_y_data;
  assign y_valid = r_y_valid;

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool_13_2.sv
`default_nettype none
// =============================================================================
// Module : tb_relu_maxpool_13_2
// Brief  : Self-checking bench; drives RELU=1 and RELU=0 instances in lockstep.
// Rev    : 1.0 - initial release
// =============================================================================
module tb_relu_maxpool_13_2;

  localparam int T = 16;
  localparam int N = 13;
  localparam int W = 2;
  localparam int K = N / W;

  typedef struct packed {
    logic [T-1:0] a;
    logic [T-1:0] b;
    logic [T-1:0] er;
    logic [T-1:0] en;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [T-1:0] x_data = '0;
  logic         x_valid = 1'b0;
  logic         y_ready = 1'b1;
  logic         xr_r, xr_n, yv_r, yv_n;
  logic [T-1:0] yd_r, yd_n;

  int total = 0;
  int bad = 0;

  logic [T-1:0] sendq[$];
  logic [T-1:0] cap_r[$];
  logic [T-1:0] cap_n[$];
  logic [T-1:0] exp_r[$];
  logic [T-1:0] exp_n[$];
  logic [T-1:0] vec[N];
  logic         hold_r = 1'b0;
  logic         hold_n = 1'b0;
  logic [T-1:0] held_r = '0;
  logic [T-1:0] held_n = '0;
  vec_t         tbl[6];

  relu_maxpool_13_2 #(.T(T), .N(N), .W(W), .RELU(1'b1)) dut_r (
    .clk(clk), .reset(reset), .x_data(x_data), .x_valid(x_valid), .x_ready(xr_r),
    .y_data(yd_r), .y_valid(yv_r), .y_ready(y_ready)
  );

  relu_maxpool_13_2 #(.T(T), .N(N), .W(W), .RELU(1'b0)) dut_n (
    .clk(clk), .reset(reset), .x_data(x_data), .x_valid(x_valid), .x_ready(xr_n),
    .y_data(yd_n), .y_valid(yv_n), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  // Output capture plus stability of a stalled result.
  always @(negedge clk) begin
    if (reset) begin
      hold_r = 1'b0;
      hold_n = 1'b0;
    end else begin
      if (hold_r) begin
        chk("hold y_valid_r", {31'd0, yv_r}, 32'd1);
        chk("hold y_data_r", {16'd0, yd_r}, {16'd0, held_r});
      end
      if (hold_n) begin
        chk("hold y_valid_n", {31'd0, yv_n}, 32'd1);
        chk("hold y_data_n", {16'd0, yd_n}, {16'd0, held_n});
      end
      if (yv_r && y_ready) cap_r.push_back(yd_r);
      if (yv_n && y_ready) cap_n.push_back(yd_n);
      hold_r = yv_r && !y_ready;
      hold_n = yv_n && !y_ready;
      held_r = yd_r;
      held_n = yd_n;
    end
  end

  function automatic int act(input logic [T-1:0] v, input bit relu);
    int s;
    s = $signed(v);
    return (relu && s < 0) ? 0 : s;
  endfunction

  // Reference: each window's maximum after activation; trailing elements dropped.
  task automatic push_vec();
    for (int i = 0; i < N; i++) sendq.push_back(vec[i]);
    for (int k = 0; k < K; k++) begin
      int mr;
      int mn;
      mr = act(vec[k*W], 1'b1);
      mn = act(vec[k*W], 1'b0);
      for (int j = 1; j < W; j++) begin
        if (act(vec[k*W+j], 1'b1) > mr) mr = act(vec[k*W+j], 1'b1);
        if (act(vec[k*W+j], 1'b0) > mn) mn = act(vec[k*W+j], 1'b0);
      end
      exp_r.push_back(mr[T-1:0]);
      exp_n.push_back(mn[T-1:0]);
    end
  endtask

  task automatic run(input int pv, input int pr, input int n_out, input int budget);
    int cyc;
    cyc = 0;
    while ((sendq.size() > 0 || cap_r.size() < n_out) && cyc < budget) begin
      x_valid = (sendq.size() > 0) && ($urandom_range(99) < pv);
      x_data  = x_valid ? sendq[0] : T'($urandom);
      y_ready = ($urandom_range(99) < pr);
      @(negedge clk);
      if (x_valid && xr_r) void'(sendq.pop_front());
      @(posedge clk);
      #1;
      cyc++;
    end
    x_valid = 1'b0;
    y_ready = 1'b1;
    chk("run within budget", {31'd0, cyc < budget}, 32'd1);
    sendq.delete();
  endtask

  task automatic check_caps(input string tag);
    chk({tag, " count_r"}, cap_r.size(), exp_r.size());
    chk({tag, " count_n"}, cap_n.size(), exp_n.size());
    for (int i = 0; i < exp_r.size() && i < cap_r.size(); i++)
      chk({tag, " data_r"}, {16'd0, cap_r[i]}, {16'd0, exp_r[i]});
    for (int i = 0; i < exp_n.size() && i < cap_n.size(); i++)
      chk({tag, " data_n"}, {16'd0, cap_n[i]}, {16'd0, exp_n[i]});
    cap_r.delete();
    cap_n.delete();
    exp_r.delete();
    exp_n.delete();
  endtask

  initial begin
    tbl[0] = '{16'hFFFB, 16'hFFFD, 16'h0000, 16'hFFFD};
    tbl[1] = '{16'hFFFF, 16'h0007, 16'h0007, 16'h0007};
    tbl[2] = '{16'h7FFF, 16'h8000, 16'h7FFF, 16'h7FFF};
    tbl[3] = '{16'h8000, 16'h8000, 16'h0000, 16'h8000};
    tbl[4] = '{16'h0003, 16'h0003, 16'h0003, 16'h0003};
    tbl[5] = '{16'h8000, 16'hFFFF, 16'h0000, 16'hFFFF};

    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("reset y_valid_r", {31'd0, yv_r}, 32'd0);
    chk("reset y_data_r", {16'd0, yd_r}, 32'd0);
    chk("reset x_ready_r", {31'd0, xr_r}, 32'd1);
    chk("reset y_valid_n", {31'd0, yv_n}, 32'd0);
    chk("reset y_data_n", {16'd0, yd_n}, 32'd0);
    chk("reset x_ready_n", {31'd0, xr_n}, 32'd1);
    @(posedge clk);
    #1;

    // Sequential vectors at full rate
    for (int i = 0; i < N; i++) vec[i] = T'(i + 1);
    push_vec();
    for (int i = 0; i < N; i++) vec[i] = T'(i + 20);
    push_vec();
    run(100, 100, exp_r.size(), 200);
    check_caps("seq");

    // Activation and extreme-value pairs
    for (int t = 0; t < 6; t++) begin
      sendq.push_back(tbl[t].a);
      sendq.push_back(tbl[t].b);
      for (int i = 2; i < N; i++) sendq.push_back('0);
      run(100, 100, K, 200);
      chk("tbl count", cap_r.size(), K);
      if (cap_r.size() > 0) chk("tbl relu", {16'd0, cap_r[0]}, {16'd0, tbl[t].er});
      if (cap_n.size() > 0) chk("tbl raw", {16'd0, cap_n[0]}, {16'd0, tbl[t].en});
      cap_r.delete();
      cap_n.delete();
    end

    // Backpressure with a pending result
    y_ready = 1'b0;
    x_valid = 1'b1;
    x_data  = 16'd10;
    @(posedge clk);
    #1;
    x_data = 16'd20;
    @(posedge clk);
    #1;
    x_data = 16'd30;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp y_valid", {31'd0, yv_r}, 32'd1);
      chk("bp y_data", {16'd0, yd_r}, 32'd20);
      chk("bp x_ready_r", {31'd0, xr_r}, 32'd0);
      chk("bp x_ready_n", {31'd0, xr_n}, 32'd0);
      @(posedge clk);
      #1;
    end
    y_ready = 1'b1;
    @(negedge clk);
    chk("bp resume x_ready", {31'd0, xr_r}, 32'd1);
    @(posedge clk);
    #1;
    x_data = 16'd40;
    @(posedge clk);
    #1;
    x_valid = 1'b0;
    chk("bp drain count", cap_r.size(), 1);
    if (cap_r.size() > 0) chk("bp drain data", {16'd0, cap_r[0]}, 32'd20);
    cap_r.delete();
    cap_n.delete();
    for (int i = 5; i <= 13; i++) sendq.push_back(T'(i * 10));
    for (int i = 0; i < 5; i++) begin
      exp_r.push_back(T'(40 + i * 20));
      exp_n.push_back(T'(40 + i * 20));
    end
    run(100, 100, 5, 200);
    check_caps("bp tail");

    // Reset in the middle of a vector
    for (int i = 0; i < 5; i++) sendq.push_back(T'(1000 + i * 100));
    run(100, 100, 2, 100);
    cap_r.delete();
    cap_n.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst y_valid", {31'd0, yv_r}, 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) vec[i] = T'(i + 1);
    push_vec();
    run(100, 100, K, 200);
    check_caps("midrst");

    // Random-stall soak driven by a convolver model
    for (int v = 0; v < 625; v++) begin
      logic [T-1:0] xs[16];
      int h[4];
      for (int i = 0; i < 16; i++) xs[i] = T'($urandom);
      for (int i = 0; i < 4; i++) h[i] = int'($urandom_range(15)) - 8;
      for (int j = 0; j < N; j++) begin
        int s;
        s = 0;
        for (int i = 0; i < 4; i++) s += int'($signed(xs[j+i])) * h[i];
        vec[j] = s[T-1:0];
      end
      push_vec();
    end
    run(70, 70, exp_r.size(), 60000);
    check_caps("soak");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/relu_maxpool_13_2.md
Name: relu_maxpool_13_2

Overview:
- Streaming activation and pooling stage placed directly downstream of conv_16_4_16_1.
- Consumes that convolver's output stream: 13 signed T-bit values per input vector (16 inputs, 4 taps, 16 − 4 + 1 = 13).
- Applies optional ReLU, then non-overlapping max-pooling with window W and stride W.
- Emits floor(N/W) values per vector over the same valid/ready handshake the convolver uses.

Parameters:
- T, 16, data width in bits (two's complement).
- N, 13, elements per input vector (convolver output length).
- W, 2, pooling window size and stride; legal range 1 <= W <= N.
- RELU, 1, 1 = clamp negative values to 0 before pooling; 0 = bypass.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- x_data  input  T  signed input sample (convolver y_data).
- x_valid  input  1  x_data valid.
- x_ready  output  1  block accepts x_data this cycle.
- y_data  output  T  signed pooled result.
- y_valid  output  1  y_data valid.
- y_ready  input  1  downstream accepts y_data.

Behaviour:
- Transfer rules: input transfer when x_valid && x_ready at posedge; output transfer when y_valid && y_ready at posedge.
- Reset values: y_valid=0, y_data=0, element index idx=0, running max acc=0. x_ready=1 after reset.
- x_ready = ~y_valid | y_ready (combinational). No bubble under continuous flow.
- Counters: idx counts 0..N-1 and wraps to 0 after element N-1. Window position p = idx mod W, tracked by its own counter that resets with idx wrap. K = floor(N/W) windows per vector; NP = K*W pooled elements.
- Activation per accepted sample: a = (RELU && x_data<0) ? 0 : x_data. Signed comparison; no width growth.
- Accepted sample with idx < NP:
  - p==0 and W>1: acc <= a.
  - 0<p<W-1: acc <= max(acc, a).
  - p==W-1: y_data <= (W==1) ? a : max(acc, a); y_valid <= 1.
- Accepted sample with idx >= NP (trailing partial window, default element 12): consumed and discarded, no output, acc unchanged.
- Output register: y_valid clears on output transfer unless a new result loads in the same cycle, in which case y_valid stays 1 with the new y_data.
- While y_valid && !y_ready: y_data and y_valid held stable; x_ready=0.
- Latency: result valid in the cycle after its last window element is accepted.
- Throughput: 1 input/cycle; default produces 6 outputs per 13 inputs.
- Tie on max: value is identical, so no ordering concern.
- Reset mid-vector: idx, p and acc cleared, pending output dropped. The next accepted sample is element 0 of a new vector.
- x_data is ignored when x_valid=0 (may be X); must not propagate X into acc.

Test Plan:
- Sequential values: vector 1,2,…,13 with x_valid=y_ready=1 → y = 2,4,6,8,10,12; element 13 discarded; next vector's first output taken from its own elements 0,1.
- ReLU on (RELU=1): pairs (-5,-3) → 0; (-1,7) → 7. With RELU=0: (-5,-3) → -3 (0xFFFD).
- Extremes: pair (0x7FFF, 0x8000) with RELU=0 → 0x7FFF; pair (0x8000, 0x8000) → 0x8000 (RELU=0) or 0x0000 (RELU=1).
- Backpressure: hold y_ready=0 for 5 cycles with a result pending → y_data stable, x_ready=0, no input consumed. Release → result drains, and input resumes in the same cycle.
- Reset mid-vector: assert reset after 5 elements of vector A, then stream full vector B=1..13 → outputs exactly 2,4,…,12 with no residue from A.
- Random stall soak: randomized x_valid/y_ready, 625 vectors from a convolver reference model → 3750 outputs, all matching the golden max-pool.
